ex_muldiv: RTL and testbench

//  Iterative RV32M multiply/divide unit alongside the EX stage ALU.
//  - Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU op.
//  - Raises stall_req_o while computing, so the pipeline holds EX.
//  - Returns wd_o/wreg_o/wdata_o in the same format as the ALU result path.

---
 rtl/ex_muldiv.sv | 183 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU beside the EX ALU; MULDIV_EARLY_OUT_EN enables 1-cycle special cases.
// Latency: done_o ITERS+1 cycles after start_i is first presented (1 cycle for early-out cases when enabled).
// Backpressure: stall_req_o holds EX from the accepting cycle through CALC and drops in DONE so EX advances.
module ex_muldiv #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    input  logic [4:0]      wd_i,
    input  logic            flush_i,
    output logic            stall_req_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [4:0]      wd_o,
    output logic            wreg_o,
    output logic [XLEN-1:0] wdata_o
);
    localparam int ITERS = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   acc_hi, acc_lo, opb;
    logic [2:0]        op_q;
    logic [4:0]        wd_q;
    logic              neg1_q, neg2_q;

    logic              accept, sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN-1:0]   nxt_hi, nxt_lo, calc_res, quo, rem;
    logic [2*XLEN-1:0] prod;
    logic [XLEN:0]     step;
    logic              qbit;

    // Operand decode: MULHSU treats rs2 as unsigned; the U ops treat both as unsigned.
    always_comb begin
        sgn1 = (op_i != 3'd3) && (op_i != 3'd5) && (op_i != 3'd7);
        sgn2 = sgn1 && (op_i != 3'd2);
        neg1 = sgn1 && reg1_i[XLEN-1];
        neg2 = sgn2 && reg2_i[XLEN-1];
        mag1 = neg1 ? -reg1_i : reg1_i;
        mag2 = neg2 ? -reg2_i : reg2_i;
    end

    assign accept      = (state == IDLE) && start_i && !flush_i;
    assign stall_req_o = accept || (state == CALC);
    assign busy_o      = (state != IDLE);

`ifdef MULDIV_EARLY_OUT_EN
    logic            early;
    logic [XLEN-1:0] early_res;

    always_comb begin
        early     = 1'b0;
        early_res = '0;
        if (op_i[2]) begin
            if (reg2_i == '0) begin
                early     = 1'b1;
                early_res = op_i[1] ? reg1_i : '1;
            end else if (sgn1 && (reg1_i == {1'b1, {(XLEN-1){1'b0}}}) && (reg2_i == '1)) begin
                early     = 1'b1;
                early_res = op_i[1] ? '0 : reg1_i;
            end
        end else if ((reg1_i == '0) || (reg2_i == '0)) begin
            early = 1'b1;
        end
    end
`endif

    // One CALC cycle: BITS_PER_CYCLE shift-add (multiply) or restoring (divide) steps.
    always_comb begin
        nxt_hi = acc_hi;
        nxt_lo = acc_lo;
        step   = '0;
        qbit   = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_q[2]) begin
                step   = {nxt_hi, nxt_lo[XLEN-1]};
                qbit   = (step >= {1'b0, opb});
                if (qbit) step = step - {1'b0, opb};
                nxt_hi = step[XLEN-1:0];
                nxt_lo = {nxt_lo[XLEN-2:0], qbit};
            end else begin
                step   = {1'b0, nxt_hi} + {1'b0, opb & {XLEN{nxt_lo[0]}}};
                nxt_hi = step[XLEN:1];
                nxt_lo = {step[0], nxt_lo[XLEN-1:1]};
            end
        end
    end

    // Divide by zero leaves rem = |rs1|, so only the quotient needs forcing.
    always_comb begin
        prod = {nxt_hi, nxt_lo};
        if (neg1_q ^ neg2_q) prod = -prod;
        quo = (neg1_q ^ neg2_q) ? -nxt_lo : nxt_lo;
        rem = neg1_q ? -nxt_hi : nxt_hi;
        if (opb == '0) quo = '1;
        case (op_q)
            3'd0:             calc_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: calc_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       calc_res = quo;
            default:          calc_res = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MULDIV_EARLY_OUT_EN
                    state_nxt = early ? DONE : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush_i) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opb     <= '0;
            op_q    <= '0;
            wd_q    <= '0;
            neg1_q  <= 1'b0;
            neg2_q  <= 1'b0;
            done_o  <= 1'b0;
            wreg_o  <= 1'b0;
            wd_o    <= '0;
            wdata_o <= '0;
        end else begin
            done_o <= 1'b0;
            if (accept) begin
                cnt    <= CNT_W'(ITERS - 1);
                acc_hi <= '0;
                acc_lo <= mag1;
                opb    <= mag2;
                op_q   <= op_i;
                wd_q   <= wd_i;
                neg1_q <= neg1;
                neg2_q <= neg2;
`ifdef MULDIV_EARLY_OUT_EN
                if (early) begin
                    done_o  <= 1'b1;
                    wreg_o  <= (wd_i != 5'd0);
                    wd_o    <= wd_i;
                    wdata_o <= early_res;
                end
`endif
            end else if ((state == CALC) && !flush_i) begin
                acc_hi <= nxt_hi;
                acc_lo <= nxt_lo;
                cnt    <= cnt - CNT_W'(1);
                if (cnt == '0) begin
                    done_o  <= 1'b1;
                    wreg_o  <= (wd_q != 5'd0);
                    wd_o    <= wd_q;
                    wdata_o <= calc_res;
                end
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected results, a negedge monitor pops and compares on done_o.
module tb_ex_muldiv;
    localparam int FULL_LAT = 33;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO = 1;
`else
    localparam int EO = 0;
`endif
    localparam int NV = 19;

    logic        clk = 1'b0;
    logic        rst, start_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        stall_req_o, busy_o, done_o, wreg_o;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o;

    ex_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .flush_i(flush_i),
        .stall_req_o(stall_req_o), .busy_o(busy_o), .done_o(done_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dat;
        logic [4:0]  wd;
        logic        wreg;
        int          due;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // op, rs1, rs2, wd, expected, early-out case
    logic [2:0]  v_op  [NV] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd0,
                                3'd3, 3'd4, 3'd6, 3'd4, 3'd6, 3'd0, 3'd5, 3'd4, 3'd6};
    logic [31:0] v_a   [NV] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                32'hFFFFFFF9, 32'd100, 32'd100, 32'hFFFFFFF9, 32'h0000FFFF,
                                32'h00010000, 32'h000004D2, 32'd5, 32'h80000000, 32'h80000000,
                                32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] v_b   [NV] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                                32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'h0000FFFF,
                                32'h00010000, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'd5, 32'd1, 32'd0, 32'd0};
    logic [4:0]  v_wd  [NV] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                5'd0, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd31, 5'd16, 5'd17};
    logic [31:0] v_exp [NV] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD,
                                32'hFFFFFFFF, 32'd14, 32'd2, 32'd3, 32'hFFFE0001,
                                32'd1, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0,
                                32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    bit          v_eo  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b1 && done_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done_o=1 at cycle %0d with no op outstanding", cyc);
            end else begin
                e = sb.pop_front();
                check($sformatf("wdata[%0d]", e.id), wdata_o, e.dat);
                check($sformatf("wd[%0d]", e.id), {27'b0, wd_o}, {27'b0, e.wd});
                check($sformatf("wreg[%0d]", e.id), {31'b0, wreg_o}, {31'b0, e.wreg});
                check($sformatf("latency[%0d]", e.id), 32'(cyc), 32'(e.due));
                check($sformatf("stall_in_done[%0d]", e.id), {31'b0, stall_req_o}, 32'd0);
            end
        end
    end

    // Called at a negedge; drives the op and waits until the unit is IDLE so it is accepted next edge.
    task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] wd, input logic [31:0] exp, input int lat,
                           input bit track, input int id);
        int   guard = 0;
        exp_t e;
        start_i = 1'b1;
        op_i    = op;
        reg1_i  = a;
        reg2_i  = b;
        wd_i    = wd;
        while (busy_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (busy_o) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout[%0d]: busy_o still 1 after %0d cycles", id, guard);
        end
        check($sformatf("stall_accept[%0d]", id), {31'b0, stall_req_o}, 32'd1);
        if (track) begin
            e.dat  = exp;
            e.wd   = wd;
            e.wreg = (wd != 5'd0);
            e.due  = cyc + lat;
            e.id   = id;
            sb.push_back(e);
        end
    endtask

    // start_i stays high until done_o is seen, as a held EX instruction would keep it.
    task automatic wait_done(input int lat, input int id);
        int n = 0;
        int guard = 0;
        while (done_o !== 1'b1 && guard < 200) begin
            if (stall_req_o) n++;
            @(negedge clk);
            guard++;
        end
        if (done_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout[%0d]: no done_o within %0d cycles", id, guard);
        end
        check($sformatf("stall_cycles[%0d]", id), 32'(n), 32'(lat));
    endtask

    initial begin
        int lat;
        rst = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        op_i = 3'd0; reg1_i = '0; reg2_i = '0; wd_i = '0;
        repeat (3) @(negedge clk);
        check("reset_done", {31'b0, done_o}, 32'd0);
        check("reset_wreg", {31'b0, wreg_o}, 32'd0);
        check("reset_wd", {27'b0, wd_o}, 32'd0);
        check("reset_wdata", wdata_o, 32'd0);
        check("reset_busy", {31'b0, busy_o}, 32'd0);
        check("reset_stall", {31'b0, stall_req_o}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Back-to-back ops; next op is driven in the DONE cycle with start_i still high.
        for (int i = 0; i < NV; i++) begin
            lat = (v_eo[i] && EO == 1) ? 1 : FULL_LAT;
            present(v_op[i], v_a[i], v_b[i], v_wd[i], v_exp[i], lat, 1'b1, i);
            wait_done(lat, i);
        end

        // Flush at CALC cycle 10, then a new op accepted straight away.
        present(3'd0, 32'd3, 32'd4, 5'd20, 32'd12, FULL_LAT, 1'b0, 100);
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_idle", {31'b0, busy_o}, 32'd0);
        present(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, FULL_LAT, 1'b1, 101);
        wait_done(FULL_LAT, 101);

        // Reset in the middle of CALC.
        present(3'd3, 32'h00010000, 32'h00010000, 5'd6, 32'd1, FULL_LAT, 1'b0, 102);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check("midrst_done", {31'b0, done_o}, 32'd0);
        check("midrst_wreg", {31'b0, wreg_o}, 32'd0);
        check("midrst_wd", {27'b0, wd_o}, 32'd0);
        check("midrst_wdata", wdata_o, 32'd0);
        check("midrst_busy", {31'b0, busy_o}, 32'd0);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
